// File: rtl/spi_mnrch_cfg.sv
// SPI master with configurable word width, SCLK divider, SPI mode and slave count.
// Shifts one word out MSB first on MOSI while collecting the same number of bits from MISO.
module spi_mnrch_cfg #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 32,
  parameter int CPOL     = 1,
  parameter int CPHA     = 1,
  parameter int NUM_SS   = 1,
  parameter int SS_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snd,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SS_W-1:0]   ss_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] resp,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int H      = SCLK_DIV / 2;
  localparam int CNT_W  = $clog2(SCLK_DIV);
  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES + 1);

  localparam logic             IDLE_LVL   = (CPOL != 0);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(H - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRONT = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_BACK  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] sr;

  logic [EDGE_W-1:0] next_edge;
  logic              is_sample;
  logic              is_last;
  logic              drive;
  logic [NUM_SS-1:0] sel_onehot;

  // Handshake: snd is a request that is taken only when the FSM is idle (including
  // the done cycle); busy then covers the transfer up to and including the done pulse.
  assign busy = (state != ST_IDLE) || done;

  always_comb begin
    next_edge = edge_cnt + EDGE_W'(1);
    is_sample = (CPHA == 0) ? next_edge[0] : ~next_edge[0];
    is_last   = (next_edge == EDGE_W'(EDGES));
    // The final edge never launches a new bit; with CPHA=1 it is a sample edge anyway.
    drive     = ~is_sample && ~is_last;
    sel_onehot = (32'(ss_sel) < NUM_SS) ? (NUM_SS'(1) << ss_sel) : NUM_SS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      sr       <= '0;
      resp     <= '0;
      SS_n     <= '1;
      SCLK     <= IDLE_LVL;
      MOSI     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (snd) begin
            sr       <= cmd;
            SS_n     <= ~sel_onehot;
            div_cnt  <= CNT_RELOAD;
            edge_cnt <= '0;
            state    <= ST_FRONT;
            if (CPHA == 0) MOSI <= cmd[DATA_W-1];
          end
        end
        ST_FRONT, ST_SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt  <= CNT_RELOAD;
            edge_cnt <= next_edge;
            SCLK     <= ~SCLK;
            if (is_sample) sr <= {sr[DATA_W-2:0], MISO};
            if (drive) MOSI <= sr[DATA_W-1];
            state <= is_last ? ST_BACK : ST_SHIFT;
          end else begin
            div_cnt <= div_cnt - CNT_W'(1);
          end
        end
        ST_BACK: begin
          if (div_cnt == '0) begin
            SS_n  <= '1;
            done  <= 1'b1;
            resp  <= sr;
            state <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mnrch_cfg.sv
// Bench for spi_mnrch_cfg: five instances (default config plus four SPI modes at DATA_W=8).
// A cycle-offset model and a reactive SPI slave run at every negedge.
module tb_spi_mnrch_cfg;

  localparam int N = 5;

  logic        clk;
  logic        rst;
  logic        snd_a  [N];
  logic [15:0] cmd_a  [N];
  logic [2:0]  sel_a  [N];
  logic        busy_a [N];
  logic        done_a [N];
  logic [15:0] resp_a [N];
  logic [3:0]  ss_a   [N];
  logic        sclk_a [N];
  logic        mosi_a [N];
  logic        miso_a [N];

  int n_total;
  int n_bad;
  int cyc;

  // model state
  logic        m_act  [N];
  int          m_t0   [N];
  logic [15:0] m_c    [N];
  int          m_s    [N];
  logic [15:0] m_w    [N];
  logic [15:0] m_resp [N];
  logic        m_mosi [N];
  logic [15:0] slv_w  [N];
  int          t_acc  [N];
  // slave state
  logic        s_psel  [N];
  logic        s_psclk [N];
  int          s_bi    [N];
  logic [15:0] s_rx    [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DW  = (g == 0) ? 16 : 8;
    localparam int DIV = (g == 0) ? 32 : 4;
    localparam int NSS = (g == 0) ? 1 : 4;
    localparam int SSW = (g == 0) ? 1 : 3;
    localparam int CP  = (g == 0) ? 1 : ((g - 1) / 2);
    localparam int CH  = (g == 0) ? 1 : ((g - 1) % 2);
    logic [NSS-1:0] ss_w;
    logic [DW-1:0]  resp_w;
    spi_mnrch_cfg #(
      .DATA_W(DW), .SCLK_DIV(DIV), .CPOL(CP), .CPHA(CH), .NUM_SS(NSS), .SS_W(SSW)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .snd    (snd_a[g]),
      .cmd    (cmd_a[g][DW-1:0]),
      .ss_sel (sel_a[g][SSW-1:0]),
      .busy   (busy_a[g]),
      .done   (done_a[g]),
      .resp   (resp_w),
      .SS_n   (ss_w),
      .SCLK   (sclk_a[g]),
      .MOSI   (mosi_a[g]),
      .MISO   (miso_a[g])
    );
    assign resp_a[g] = 16'(resp_w);
    assign ss_a[g]   = (4'hF << NSS) | 4'(ss_w);
  end

  function automatic int cfg_dw(input int i);   return (i == 0) ? 16 : 8; endfunction
  function automatic int cfg_h(input int i);    return (i == 0) ? 16 : 2; endfunction
  function automatic int cfg_nss(input int i);  return (i == 0) ? 1 : 4; endfunction
  function automatic int cfg_cpol(input int i); return (i == 0) ? 1 : ((i - 1) / 2); endfunction
  function automatic int cfg_cpha(input int i); return (i == 0) ? 1 : ((i - 1) % 2); endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected outputs follow from the cycle offset d since accept: edge k shows at d=1+k*H,
  // done at d=1+(2*DW+1)*H.
  task automatic model_cycle();
    int dw, h, cp, ch, len, d, e, k;
    logic [15:0] mask;
    logic [3:0]  e_ss;
    logic        e_sclk, e_mosi, e_busy, e_done, sel_now, lead;
    for (int i = 0; i < N; i++) begin
      dw = cfg_dw(i); h = cfg_h(i); cp = cfg_cpol(i); ch = cfg_cpha(i);
      len  = 1 + (2 * dw + 1) * h;
      mask = 16'((32'd1 << dw) - 1);
      e_busy = 1'b0; e_done = 1'b0; e_ss = 4'hF; e_sclk = (cp != 0); e_mosi = m_mosi[i];
      if (rst) begin
        m_act[i] = 1'b0; m_resp[i] = '0; m_mosi[i] = 1'b0; e_mosi = 1'b0;
      end else begin
        if (m_act[i]) begin
          d = cyc - m_t0[i];
          e = (d - 1) / h;
          if (e > 2 * dw) e = 2 * dw;
          e_busy = 1'b1;
          e_done = (d == len);
          if (d < len) e_ss[m_s[i]] = 1'b0;
          e_sclk = ((cp + e) % 2) != 0;
          if (ch == 0) begin
            k = e / 2;
            if (k > dw - 1) k = dw - 1;
            e_mosi = m_c[i][dw-1-k];
          end else begin
            k = (e + 1) / 2;
            if (k > 0) e_mosi = m_c[i][dw-k];
          end
          if (e_done) begin
            m_resp[i] = m_w[i];
            m_act[i]  = 1'b0;
            chk($sformatf("slave_rx[%0d]", i), 32'(s_rx[i] & mask), 32'(m_c[i]));
          end
        end
        m_mosi[i] = e_mosi;
      end
      chk($sformatf("busy[%0d]", i), 32'(busy_a[i]), 32'(e_busy));
      chk($sformatf("done[%0d]", i), 32'(done_a[i]), 32'(e_done));
      chk($sformatf("ss_n[%0d]", i), 32'(ss_a[i]), 32'(e_ss));
      chk($sformatf("sclk[%0d]", i), 32'(sclk_a[i]), 32'(e_sclk));
      chk($sformatf("mosi[%0d]", i), 32'(mosi_a[i]), 32'(e_mosi));
      chk($sformatf("resp[%0d]", i), 32'(resp_a[i]), 32'(m_resp[i]));
      if (!rst && snd_a[i] && !m_act[i]) begin
        m_act[i] = 1'b1;
        m_t0[i]  = cyc;
        m_c[i]   = cmd_a[i] & mask;
        m_s[i]   = (int'(sel_a[i]) >= cfg_nss(i)) ? 0 : int'(sel_a[i]);
        m_w[i]   = slv_w[i] & mask;
      end
      // mode-matched slave reacting to SS_n/SCLK
      sel_now = (ss_a[i] != 4'hF);
      if (sel_now && !s_psel[i]) begin
        s_bi[i] = 0; s_rx[i] = '0;
        if (ch == 0) begin
          miso_a[i] = m_w[i][dw-1];
          s_bi[i] = 1;
        end
      end else if (sel_now && (sclk_a[i] != s_psclk[i])) begin
        lead = (s_psclk[i] == (cp != 0));
        if (lead == (ch != 0)) begin
          if (s_bi[i] < dw) begin
            miso_a[i] = m_w[i][dw-1-s_bi[i]];
            s_bi[i]++;
          end
        end else begin
          s_rx[i] = {s_rx[i][14:0], mosi_a[i]};
        end
      end
      s_psel[i]  = sel_now;
      s_psclk[i] = sclk_a[i];
    end
  endtask

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic send(input int i, input logic [15:0] c, input logic [2:0] s, input logic [15:0] w);
    snd_a[i] = 1'b1; cmd_a[i] = c; sel_a[i] = s; slv_w[i] = w; t_acc[i] = cyc;
    step(1);
    snd_a[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int lat, output int nbusy,
                           output int nedges);
    logic ps;
    lat = -1; nbusy = 0; nedges = 0; ps = sclk_a[i];
    for (int k = 0; k < budget; k++) begin
      if (busy_a[i]) nbusy++;
      if (sclk_a[i] != ps) nedges++;
      ps = sclk_a[i];
      if (done_a[i]) begin
        lat = cyc - t_acc[i];
        break;
      end
      step(1);
    end
    if (lat < 0) chk($sformatf("done_timeout[%0d]", i), 32'd0, 32'd1);
  endtask

  initial begin : main
    int lat, nb, ne, cnt;
    logic [7:0] pat_c [3];
    logic [7:0] pat_w [3];
    n_total = 0; n_bad = 0; cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      snd_a[i] = 1'b0; cmd_a[i] = '0; sel_a[i] = '0; slv_w[i] = '0; miso_a[i] = 1'b0;
      m_act[i] = 1'b0; m_t0[i] = 0; m_c[i] = '0; m_s[i] = 0; m_w[i] = '0;
      m_resp[i] = '0; m_mosi[i] = 1'b0; t_acc[i] = 0;
      s_psel[i] = 1'b0; s_psclk[i] = (cfg_cpol(i) != 0); s_bi[i] = 0; s_rx[i] = '0;
    end
    step(3);
    rst = 1'b0;
    step(2);

    // default config: cmd 1234, slave A5C3
    chk("idle_sclk0", 32'(sclk_a[0]), 32'd1);
    send(0, 16'h1234, 3'd0, 16'hA5C3);
    chk("ss_sel0", 32'(ss_a[0]), 32'hE);
    wait_done(0, 600, lat, nb, ne);
    chk("lat_default", 32'(lat), 32'd529);
    chk("busy_cycles", 32'(nb), 32'd529);
    chk("edges_default", 32'(ne), 32'd32);
    chk("resp_default", 32'(resp_a[0]), 32'hA5C3);
    step(2);

    // all four modes: loopback patterns and one distinct slave word
    pat_c[0] = 8'hFF; pat_w[0] = 8'hFF;
    pat_c[1] = 8'h00; pat_w[1] = 8'h00;
    pat_c[2] = 8'hC6; pat_w[2] = 8'h39;
    for (int i = 1; i < N; i++) begin
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("idle_sclk_pre[%0d]", i), 32'(sclk_a[i]), 32'(cfg_cpol(i)));
        send(i, 16'(pat_c[p]), 3'd1, 16'(pat_w[p]));
        wait_done(i, 60, lat, nb, ne);
        chk($sformatf("lat_mode[%0d]", i), 32'(lat), 32'd35);
        chk($sformatf("resp_mode[%0d]", i), 32'(resp_a[i]), 32'(pat_w[p]));
        step(1);
        chk($sformatf("idle_sclk_post[%0d]", i), 32'(sclk_a[i]), 32'(cfg_cpol(i)));
      end
    end

    // DATA_W=8, SCLK_DIV=4, NUM_SS=4, ss_sel=2
    send(4, 16'h0081, 3'd2, 16'h005A);
    chk("ss_sel2", 32'(ss_a[4]), 32'hB);
    wait_done(4, 60, lat, nb, ne);
    chk("lat_small", 32'(lat), 32'd35);
    chk("edges_small", 32'(ne), 32'd16);
    chk("resp_small", 32'(resp_a[4]), 32'h005A);
    step(2);

    // snd held high with cmd changing every cycle
    slv_w[4] = 16'h003C; sel_a[4] = 3'd3;
    cnt = 0;
    for (int k = 0; k < 105; k++) begin
      snd_a[4] = 1'b1;
      cmd_a[4] = 16'(8'(k * 29 + 3));
      step(1);
      if (done_a[4]) cnt++;
    end
    snd_a[4] = 1'b0;
    chk("b2b_dones", 32'(cnt), 32'd3);
    step(2);

    // reset at edge 9 of a default transfer
    send(0, 16'hBEEF, 3'd0, 16'h1357);
    step(144);
    chk("edge9_sclk", 32'(sclk_a[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ss", 32'(ss_a[0]), 32'hF);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_sclk", 32'(sclk_a[0]), 32'd1);
    step(1);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (done_a[0]) cnt++;
    end
    chk("no_done_after_rst", 32'(cnt), 32'd0);
    chk("resp_after_rst", 32'(resp_a[0]), 32'd0);
    send(0, 16'hC0DE, 3'd0, 16'h0F0F);
    wait_done(0, 600, lat, nb, ne);
    chk("lat_after_rst", 32'(lat), 32'd529);
    chk("resp_after_rst2", 32'(resp_a[0]), 32'h0F0F);
    step(2);

    // snd while busy ignored; out-of-range ss_sel maps to slave 0
    send(0, 16'h00FF, 3'd0, 16'hFF00);
    step(99);
    snd_a[0] = 1'b1; cmd_a[0] = 16'hFFFF;
    step(1);
    snd_a[0] = 1'b0;
    wait_done(0, 600, lat, nb, ne);
    chk("lat_ignored_snd", 32'(lat), 32'd529);
    chk("resp_ignored_snd", 32'(resp_a[0]), 32'hFF00);
    step(2);
    send(4, 16'h00A7, 3'd1, 16'h0066);
    step(19);
    snd_a[4] = 1'b1; cmd_a[4] = 16'h0011; sel_a[4] = 3'd3;
    step(1);
    snd_a[4] = 1'b0;
    chk("ss_kept_sel1", 32'(ss_a[4]), 32'hD);
    wait_done(4, 60, lat, nb, ne);
    chk("resp_busy_snd", 32'(resp_a[4]), 32'h0066);
    step(2);
    send(4, 16'h003C, 3'd7, 16'h00C3);
    chk("ss_sel7", 32'(ss_a[4]), 32'hE);
    wait_done(4, 60, lat, nb, ne);
    chk("resp_sel7", 32'(resp_a[4]), 32'h00C3);
    step(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
